// File: rtl/ip_uart_tx_arbiter_if.sv
// rtl/ip_uart_tx_arbiter_if.sv - requester and ip_uart handshake bundle for ip_uart_tx_arbiter
interface ip_uart_tx_arbiter_if;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  send_data;
  logic        send_req;
  logic        send_busy;
  logic [1:0]  grant_id;
  logic        active;

  // Arbiter side: consumes requester bytes and ip_uart busy, drives the transmit request
  modport master (
    input  req_valid, req_data, req_last, send_busy,
    output req_ready, send_data, send_req, grant_id, active
  );

  // Environment side: requesters plus the ip_uart instance
  modport slave (
    output req_valid, req_data, req_last, send_busy,
    input  req_ready, send_data, send_req, grant_id, active
  );
endinterface

// File: rtl/ip_uart_tx_arbiter.sv
// rtl/ip_uart_tx_arbiter.sv - round-robin share of one ip_uart transmitter among four requesters (optional message lock: IP_UART_ARB_LOCK_EN)
module ip_uart_tx_arbiter #(
  parameter int unsigned guard_cycles = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  ip_uart_tx_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  localparam logic [3:0] GUARD_LOAD = 4'(guard_cycles);

  state_t      state_q;
  logic [7:0]  send_data_q;
  logic        send_req_q;
  logic [1:0]  grant_id_q;
  logic [1:0]  rr_ptr_q;
  logic [3:0]  guard_q;
  logic        active_q;

  logic [3:0]  eligible_d;
  logic [1:0]  grant_d;
  logic        grant_vld_d;
  logic [3:0]  req_ready_d;

`ifdef IP_UART_ARB_LOCK_EN
  logic        lock_q;
  logic [1:0]  lock_id_q;

  // While a message is open only its owner may compete
  always_comb begin
    eligible_d = bus.req_valid;
    if (lock_q) begin
      eligible_d = bus.req_valid & (4'b0001 << lock_id_q);
    end
  end
`else
  logic        unused_req_last;
  assign unused_req_last = ^bus.req_last;

  // Without message lock every valid requester competes after every byte
  always_comb begin
    eligible_d = bus.req_valid;
  end
`endif

  // Circular scan from rr_ptr; descending loop lets the nearest requester win
  always_comb begin
    grant_d     = rr_ptr_q;
    grant_vld_d = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (eligible_d[rr_ptr_q + 2'(i)]) begin
        grant_d     = rr_ptr_q + 2'(i);
        grant_vld_d = 1'b1;
      end
    end
  end

  // Consume strobe only in IDLE and never while reset is held
  always_comb begin
    req_ready_d = 4'b0000;
    if (reset_n && (state_q == ST_IDLE) && grant_vld_d) begin
      req_ready_d[grant_d] = 1'b1;
    end
  end

  // Arbitration FSM with registered handshake outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      send_data_q <= 8'h00;
      send_req_q  <= 1'b0;
      grant_id_q  <= 2'd0;
      rr_ptr_q    <= 2'd0;
      guard_q     <= 4'd0;
      active_q    <= 1'b0;
`ifdef IP_UART_ARB_LOCK_EN
      lock_q      <= 1'b0;
      lock_id_q   <= 2'd0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_vld_d) begin
            send_data_q <= bus.req_data[{grant_d, 3'b000} +: 8];
            grant_id_q  <= grant_d;
            rr_ptr_q    <= grant_d + 2'd1;
            send_req_q  <= 1'b1;
            active_q    <= 1'b1;
            state_q     <= ST_SEND;
`ifdef IP_UART_ARB_LOCK_EN
            lock_q      <= ~bus.req_last[grant_d];
            lock_id_q   <= grant_d;
`endif
          end
        end
        ST_SEND: begin
          if (!bus.send_busy) begin
            send_req_q <= 1'b0;
            guard_q    <= GUARD_LOAD;
            state_q    <= ST_GUARD;
          end
        end
        ST_GUARD: begin
          if (guard_q <= 4'd1) begin
            guard_q  <= 4'd0;
            active_q <= 1'b0;
            state_q  <= ST_IDLE;
          end else begin
            guard_q <= guard_q - 4'd1;
          end
        end
        default: begin
          send_req_q <= 1'b0;
          active_q   <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_d;
  assign bus.send_data = send_data_q;
  assign bus.send_req  = send_req_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.active    = active_q;

endmodule

// File: tb/tb_ip_uart_tx_arbiter.sv
// tb/tb_ip_uart_tx_arbiter.sv - self-checking bench for ip_uart_tx_arbiter
module tb_ip_uart_tx_arbiter;
  localparam int G = 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  ip_uart_tx_arbiter_if bus();

  ip_uart_tx_arbiter #(.guard_cycles(G)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] exp_ready;
  } comb_vec_t;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [1:0]  exp_grant;
    logic [7:0]  exp_byte;
  } rr_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    bus.req_valid = 4'b0;
    bus.req_data  = 32'h0;
    bus.req_last  = 4'b0;
    bus.send_busy = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name, output logic [3:0] rdy);
    rdy = 4'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.req_ready != 4'b0) begin
        rdy = bus.req_ready;
        break;
      end
    end
    if (rdy == 4'b0) begin
      tests++;
      fails++;
      $display("FAIL %s: got no req_ready expected a pulse within 40 cycles", name);
    end
  endtask

  function automatic int oh2idx(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return i;
    return -1;
  endfunction

  function automatic int model_winner(input logic [3:0] elig, input int rr);
    for (int k = 0; k < 4; k++) begin
      if (elig[(rr + k) % 4]) return (rr + k) % 4;
    end
    return -1;
  endfunction

  comb_vec_t cv[6];
  rr_vec_t   rv[5];

  initial begin
    logic [3:0] rdy;
    int         got[4];
    int         expg[4];
    int         n0;

    cv[0] = '{4'b0000, 4'b0000};
    cv[1] = '{4'b0001, 4'b0001};
    cv[2] = '{4'b0110, 4'b0010};
    cv[3] = '{4'b1000, 4'b1000};
    cv[4] = '{4'b1111, 4'b0001};
    cv[5] = '{4'b1100, 4'b0100};
    for (int i = 0; i < 5; i++) begin
      rv[i] = '{4'b1111, 32'h1312_1110, 2'(i % 4), 8'(8'h10 + (i % 4))};
    end

    // Reset state
    do_reset();
    @(negedge clk);
    chk("reset_send_req", {31'b0, bus.send_req}, 32'd0);
    chk("reset_send_data", {24'b0, bus.send_data}, 32'h00);
    chk("reset_req_ready", {28'b0, bus.req_ready}, 32'h0);
    chk("reset_grant_id", {30'b0, bus.grant_id}, 32'd0);
    chk("reset_active", {31'b0, bus.active}, 32'd0);

    // Combinational winner selection from rr_ptr=0, no clock edge crossed
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      bus.req_valid = cv[i].valid;
      #1;
      chk($sformatf("comb_ready_%0d", i), {28'b0, bus.req_ready}, {28'b0, cv[i].exp_ready});
    end
    bus.req_valid = 4'b0;

    // Single byte with guard of one cycle
    @(posedge clk);
    #1;
    bus.req_valid = 4'b0001;
    bus.req_data  = 32'h0000_0041;
    @(negedge clk);
    chk("single_ready", {28'b0, bus.req_ready}, 32'h1);
    @(posedge clk);
    #1;
    bus.req_valid = 4'b0000;
    @(negedge clk);
    chk("single_send_req_hi", {31'b0, bus.send_req}, 32'd1);
    chk("single_send_data", {24'b0, bus.send_data}, 32'h41);
    chk("single_active_hi", {31'b0, bus.active}, 32'd1);
    @(negedge clk);
    chk("single_send_req_lo", {31'b0, bus.send_req}, 32'd0);
    chk("single_active_guard", {31'b0, bus.active}, 32'd1);
    @(negedge clk);
    chk("single_active_lo", {31'b0, bus.active}, 32'd0);

    // Round-robin order table
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = rv[i].valid;
      bus.req_data  = rv[i].data;
      wait_ready($sformatf("rr_wait_%0d", i), rdy);
      chk($sformatf("rr_ready_%0d", i), {28'b0, rdy}, 32'(4'b0001 << rv[i].exp_grant));
      @(negedge clk);
      chk($sformatf("rr_byte_%0d", i), {24'b0, bus.send_data}, {24'b0, rv[i].exp_byte});
      chk($sformatf("rr_grant_%0d", i), {30'b0, bus.grant_id}, {30'b0, rv[i].exp_grant});
    end
    bus.req_valid = 4'b0;

    // Backpressure: busy for 20 cycles while other requesters wait
    do_reset();
    bus.send_busy = 1'b1;
    bus.req_valid = 4'b0001;
    bus.req_data  = 32'h0000_0055;
    wait_ready("bp_wait", rdy);
    @(posedge clk);
    #1;
    bus.req_valid = 4'b1111;
    bus.req_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_hold", {bus.req_ready, bus.send_req, 11'b0, bus.send_data, 8'b0},
          {4'b0000, 1'b1, 11'b0, 8'h55, 8'b0});
    end
    @(posedge clk);
    #1;
    bus.send_busy = 1'b0;
    @(negedge clk);
    chk("bp_still_req", {31'b0, bus.send_req}, 32'd1);
    @(negedge clk);
    chk("bp_handoff", {31'b0, bus.send_req}, 32'd0);
    chk("bp_no_ready_guard", {28'b0, bus.req_ready}, 32'h0);
    bus.req_valid = 4'b0;

    // Message lock versus plain alternation
    do_reset();
    bus.req_valid = 4'b0011;
    bus.req_data  = 32'h0000_2201;
    bus.req_last  = 4'b0000;
    n0 = 0;
`ifdef IP_UART_ARB_LOCK_EN
    expg = '{0, 0, 0, 1};
`else
    expg = '{0, 1, 0, 1};
`endif
    for (int b = 0; b < 4; b++) begin
      wait_ready($sformatf("lock_wait_%0d", b), rdy);
      got[b] = oh2idx(rdy);
      @(posedge clk);
      #1;
      if (got[b] == 0) begin
        n0++;
        if (n0 == 2) bus.req_last[0] = 1'b1;
        if (n0 == 3) bus.req_valid[0] = 1'b0;
      end
      chk($sformatf("lock_grant_%0d", b), 32'(got[b]), 32'(expg[b]));
    end
    bus.req_valid = 4'b0;
    bus.req_last  = 4'b0;

    // Asynchronous reset while a byte is held in SEND
    do_reset();
    bus.send_busy = 1'b1;
    bus.req_valid = 4'b0100;
    bus.req_data  = 32'h00AA_0000;
    wait_ready("rst_wait", rdy);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_pre_send_req", {31'b0, bus.send_req}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_send_req", {31'b0, bus.send_req}, 32'd0);
    chk("rst_async_ready", {28'b0, bus.req_ready}, 32'h0);
    chk("rst_async_active", {31'b0, bus.active}, 32'd0);
    bus.send_busy = 1'b0;
    bus.req_valid = 4'b0101;
    bus.req_data  = 32'h00AA_0077;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_first_ready", {28'b0, bus.req_ready}, 32'h1);
    @(posedge clk);
    #1;
    bus.req_valid = 4'b0;
    @(negedge clk);
    chk("rst_new_byte", {24'b0, bus.send_data}, 32'h77);
    chk("rst_new_grant", {30'b0, bus.grant_id}, 32'd0);

    // Randomized run against a timestamp-based reference model
    do_reset();
    begin
      bit         m_free = 1'b1;
      bit         m_send = 1'b0;
      logic [7:0] m_byte = 8'h00;
      int         m_gid = 0;
      int         m_rr = 0;
      int         m_resume = 0;
      bit         m_lock = 1'b0;
      int         m_lock_id = 0;
      logic [3:0] elig;
      logic [3:0] exp_ready;
      int         w;
      for (int n = 0; n < 2000; n++) begin
        @(posedge clk);
        #1;
        bus.req_valid = 4'($urandom_range(0, 15));
        bus.req_data  = $urandom;
        bus.req_last  = 4'($urandom_range(0, 15));
        bus.send_busy = ($urandom_range(0, 9) < 4);
        @(negedge clk);
        if (!m_free && !m_send && n == m_resume) m_free = 1'b1;
        elig = bus.req_valid;
`ifdef IP_UART_ARB_LOCK_EN
        if (m_lock) elig = bus.req_valid & (4'b0001 << m_lock_id);
`endif
        w = m_free ? model_winner(elig, m_rr) : -1;
        exp_ready = (w >= 0) ? (4'b0001 << w) : 4'b0000;
        chk("rand_ready", {28'b0, bus.req_ready}, {28'b0, exp_ready});
        chk("rand_send_req", {31'b0, bus.send_req}, {31'b0, m_send});
        chk("rand_send_data", {24'b0, bus.send_data}, {24'b0, m_byte});
        chk("rand_grant_id", {30'b0, bus.grant_id}, 32'(m_gid));
        chk("rand_active", {31'b0, bus.active}, {31'b0, !m_free});
        if (w >= 0) begin
          m_byte    = bus.req_data[w*8 +: 8];
          m_gid     = w;
          m_rr      = (w + 1) % 4;
          m_send    = 1'b1;
          m_free    = 1'b0;
          m_lock    = !bus.req_last[w];
          m_lock_id = w;
        end else if (m_send && !bus.send_busy) begin
          m_send   = 1'b0;
          m_resume = n + 1 + G;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
